// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache. Hits return data in the same
// cycle; a miss stalls the core and refills one full line from memory using
// a per-word request/ack handshake. i_flush invalidates every line.
//
// Refill handshake: o_mem_rd is held high with o_mem_addr stable until
// i_mem_ack; an ack samples i_mem_data in that same cycle. The next word's
// request is presented in the following cycle. An ack while o_mem_rd=0 is
// ignored.
module icache_dm #(
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_addr,
  output logic [31:0] o_data,
  output logic        o_valid,
  input  logic        i_flush,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_rd,
  input  logic [31:0] i_mem_data,
  input  logic        i_mem_ack
);
  localparam int INDEX_W = $clog2(LINES);
  localparam int OFFS_W  = $clog2(LINE_WORDS);
  localparam int TAG_W   = 30 - INDEX_W - OFFS_W;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t              state_q, state_d;
  logic [OFFS_W-1:0]   cnt_q, cnt_d;
  logic [TAG_W-1:0]    miss_tag_q, miss_tag_d;
  logic [INDEX_W-1:0]  miss_index_q, miss_index_d;
  logic                flush_pending_q, flush_pending_d;
  logic [LINES-1:0]    valid_q, valid_d;

  // Tag and data storage are never reset; the valid bits guard them.
  logic [TAG_W-1:0]    tag_mem  [LINES];
  logic [31:0]         data_mem [LINES][LINE_WORDS];

  logic [OFFS_W-1:0]   a_word;
  logic [INDEX_W-1:0]  a_index;
  logic [TAG_W-1:0]    a_tag;
  logic                hit;
  logic                refill_ack;
  logic                unused_addr_bits;

  assign a_word           = i_addr[OFFS_W+1:2];
  assign a_index          = i_addr[OFFS_W+INDEX_W+1:OFFS_W+2];
  assign a_tag            = i_addr[31:OFFS_W+INDEX_W+2];
  assign unused_addr_bits = ^i_addr[1:0];

  // Lookup is purely combinational so a hit costs no extra cycle.
  assign hit        = (state_q == IDLE) && valid_q[a_index] && (tag_mem[a_index] == a_tag);
  assign refill_ack = (state_q == REFILL) && i_mem_ack;

  // A flush cycle never reports a hit, even if the line was valid before it.
  assign o_valid    = hit && !i_flush;
  assign o_data     = o_valid ? data_mem[a_index][a_word] : 32'd0;
  assign o_mem_rd   = (state_q == REFILL);
  assign o_mem_addr = (state_q == REFILL) ? {miss_tag_q, miss_index_q, cnt_q, 2'b00} : 32'd0;

  // Next-state logic for the refill FSM and the valid bits.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    miss_tag_d      = miss_tag_q;
    miss_index_d    = miss_index_q;
    flush_pending_d = flush_pending_q;
    valid_d         = valid_q;
    case (state_q)
      IDLE: begin
        flush_pending_d = 1'b0;
        if (!hit) begin
          state_d          = REFILL;
          miss_tag_d       = a_tag;
          miss_index_d     = a_index;
          cnt_d            = '0;
          // Drop the line now so a half-written line can never hit.
          valid_d[a_index] = 1'b0;
        end
      end
      REFILL: begin
        if (i_flush) flush_pending_d = 1'b1;
        if (i_mem_ack) begin
          cnt_d = cnt_q + OFFS_W'(1);
          if (cnt_q == '1) begin
            state_d         = IDLE;
            flush_pending_d = 1'b0;
            if (!flush_pending_q) valid_d[miss_index_q] = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A flush in the current cycle wins over a line completing in it.
    if (i_flush) valid_d = '0;
  end

  // Control state with asynchronous reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      miss_tag_q      <= '0;
      miss_index_q    <= '0;
      flush_pending_q <= 1'b0;
      valid_q         <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      miss_tag_q      <= miss_tag_d;
      miss_index_q    <= miss_index_d;
      flush_pending_q <= flush_pending_d;
      valid_q         <= valid_d;
    end
  end

  // Refill writes into the tag and data arrays.
  always_ff @(posedge i_clk) begin
    if (refill_ack) begin
      data_mem[miss_index_q][cnt_q] <= i_mem_data;
      if (cnt_q == '1) tag_mem[miss_index_q] <= miss_tag_q;
    end
  end
endmodule
